// File: rtl/pio_in_pkg.sv
// Shared constants, bus request struct and helpers for the edge-capturing input PIO.
// PIO_IN_DEBOUNCE_EN enables the per-bit debounce filter in pio_in_bit_filter.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } pio_req_t;

  // Ceiling log2, never below 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pio_in_bit_filter.sv
// One input bit: SYNC_STAGES-deep synchroniser, plus a stable-count debounce
// filter when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_bit_filter
  import pio_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_ff <= '0;
    else          sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  // One spare bit so the incremented count cannot wrap before the compare.
  localparam int CW = clog2(DEBOUNCE_CYCLES) + 1;

  logic [CW-1:0] cnt, cnt_nxt;
  logic          filt_q;

  assign cnt_nxt = cnt + CW'(1);

  // The filtered bit flips on the same edge the count reaches DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      filt_q <= 1'b0;
    end else if (sync_q == filt_q) begin
      cnt <= '0;
    end else if (int'(cnt_nxt) >= DEBOUNCE_CYCLES - 1) begin
      filt_q <= sync_q;
      cnt    <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_q;
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture (write-1-to-clear) and masked
// level interrupt. Define PIO_IN_DEBOUNCE_EN to insert the debounce filter.
module pio_in_edge_irq
  import pio_in_pkg::*;
#(
  parameter int DATA_WIDTH      = 17,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 2,
  parameter int IRQ_EN          = 1,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  pio_req_t req;
  assign req = '{wr: chipselect & ~write_n, addr: address, wdata: writedata};

  logic [DATA_WIDTH-1:0] sync_q, prev_q, edge_det, edgecap_q, irqmask_q, clr;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign unused_wdata = ^req.wdata;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    pio_in_bit_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .dout   (sync_q[i])
    );
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_RISE)      edge_det = sync_q & ~prev_q;
    else if (EDGE_TYPE == EDGE_FALL) edge_det = ~sync_q & prev_q;
    else                             edge_det = sync_q ^ prev_q;
  end

  assign clr = (req.wr && req.addr == ADDR_EDGE) ? req.wdata[DATA_WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[DATA_WIDTH-1:0] = sync_q;
      ADDR_MASK: rd_mux[DATA_WIDTH-1:0] = irqmask_q;
      ADDR_EDGE: rd_mux[DATA_WIDTH-1:0] = edgecap_q;
      default:   rd_mux = '0;
    endcase
  end

  // New edges are OR'd in after the clear, so a colliding edge keeps its bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      edgecap_q <= '0;
      irqmask_q <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      prev_q    <= sync_q;
      edgecap_q <= (edgecap_q & ~clr) | edge_det;
      if (IRQ_EN != 0 && req.wr && req.addr == ADDR_MASK)
        irqmask_q <= req.wdata[DATA_WIDTH-1:0];
      irq       <= (IRQ_EN != 0) && (|(edgecap_q & irqmask_q));
      readdata  <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench: 17-bit rising/irq instance (A) and 32-bit any-edge, irq-disabled instance (B).
module tb_pio_in_edge_irq;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DLY = SYNC + DEB - 1;
`else
  localparam int DLY = SYNC;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a, cs_b, write_n;
  logic [31:0] writedata, rd_a, rd_b;
  logic [16:0] in_a;
  logic [31:0] in_b;
  logic        irq_a, irq_b;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.DATA_WIDTH(17), .SYNC_STAGES(SYNC), .EDGE_TYPE(0), .IRQ_EN(1),
                    .DEBOUNCE_CYCLES(DEB)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));

  pio_in_edge_irq #(.DATA_WIDTH(32), .SYNC_STAGES(SYNC), .EDGE_TYPE(2), .IRQ_EN(0),
                    .DEBOUNCE_CYCLES(DEB)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b), .write_n(write_n),
    .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = (sel == 0);
    cs_b      = (sel == 1);
    tick();
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick();
    chk(tag, (sel == 1) ? rd_b : rd_a, exp);
  endtask

  initial begin
    reset_n = 1'b0; in_a = '0; in_b = '0; address = '0;
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // irq up, then reset asynchronously mid-cycle
    in_a = 17'h1FFFF;
    wr(0, 2'd2, 32'h1FFFF);
    repeat (DLY + 3) tick();
    chk("irq_before_rst", {31'd0, irq_a}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("irq_async_rst", {31'd0, irq_a}, 32'd0);
    chk("rd_async_rst", rd_a, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;

    address = 2'd3; tick();
    chk("rst_edgecap", rd_a, 32'h0);
    chk("rst_irq", {31'd0, irq_a}, 32'd0);
    address = 2'd2; tick();
    chk("rst_mask", rd_a, 32'h0);
    address = 2'd0;
    repeat (DLY - 1) tick();
    chk("rst_data", rd_a, 32'h0001FFFF);

    // post-reset capture of the already-high inputs, masked off
    tick();
    chk("irq_masked", {31'd0, irq_a}, 32'd0);
    wr(0, 2'd3, 32'h1FFFF);

    in_a = 17'h0;
    repeat (DLY + 3) tick();
    rd(0, 2'd3, 32'h0, "fall_ignored");

    in_a = 17'h10;
    repeat (DLY + 1) tick();
    chk("rise_pre", rd_a, 32'h0);
    tick();
    chk("rise_cap", rd_a, 32'h10);
    in_a = 17'h0;
    repeat (DLY + 3) tick();
    chk("fall_hold", rd_a, 32'h10);

    // irq path
    wr(0, 2'd3, 32'h10);
    wr(0, 2'd2, 32'h10);
    tick();
    chk("irq_idle", {31'd0, irq_a}, 32'd0);
    in_a = 17'h10;
    repeat (DLY + 1) tick();
    chk("irq_pre", {31'd0, irq_a}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, irq_a}, 32'd1);
    wr(0, 2'd3, 32'h10);
    chk("irq_hold", {31'd0, irq_a}, 32'd1);
    tick();
    chk("irq_fall", {31'd0, irq_a}, 32'd0);

    // clear colliding with a fresh bit-3 edge
    wr(0, 2'd2, 32'h18);
    in_a = 17'h18;
    repeat (DLY + 3) tick();
    chk("irq_b3", {31'd0, irq_a}, 32'd1);
    in_a = 17'h10;
    repeat (DLY + 3) tick();
    in_a = 17'h18;
    repeat (DLY) tick();
    wr(0, 2'd3, 32'h8);
    rd(0, 2'd3, 32'h8, "collide_keep");
    chk("collide_irq", {31'd0, irq_a}, 32'd1);

    // write without chipselect must not clear
    address = 2'd3; writedata = 32'hFFFFFFFF; write_n = 1'b0;
    tick();
    write_n = 1'b1;
    tick();
    chk("nocs_write", rd_a, 32'h8);

    // wide any-edge instance, irq disabled
    wr(1, 2'd2, 32'hFFFFFFFF);
    rd(1, 2'd2, 32'h0, "b_mask_zero");
    in_b = 32'h80000000;
    repeat (DLY + 3) tick();
    rd(1, 2'd3, 32'h80000000, "b_rise31");
    chk("b_irq_off", {31'd0, irq_b}, 32'd0);
    wr(1, 2'd3, 32'h80000000);
    rd(1, 2'd3, 32'h0, "b_clr");
    in_b = 32'h0;
    repeat (DLY + 3) tick();
    rd(1, 2'd3, 32'h80000000, "b_fall31");
    in_b = 32'h12345678;
    repeat (DLY + 3) tick();
    wr(1, 2'd0, 32'hFFFFFFFF);
    wr(1, 2'd1, 32'hFFFFFFFF);
    rd(1, 2'd0, 32'h12345678, "b_data");
    rd(1, 2'd1, 32'h0, "b_rsvd");
    rd(1, 2'd3, 32'h92345678, "b_any_multi");

`ifdef PIO_IN_DEBOUNCE_EN
    // 5-cycle glitch is filtered; a held level captures 8 cycles after sync_q rises
    address = 2'd3;
    in_a = 17'h19;
    repeat (5) tick();
    in_a = 17'h18;
    repeat (20) tick();
    chk("db_glitch", rd_a, 32'h8);
    in_a = 17'h19;
    repeat (SYNC + DEB) tick();
    chk("db_pre", rd_a, 32'h8);
    tick();
    chk("db_cap", rd_a, 32'h9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
